stream_arbiter: RTL and testbench

Round-robin arbiter that shares the `router` input stream among `source_count` upstream producers. Each source presents a ready/valid stream tagged with a routing identity. The block grants one source at a time for a bounded burst and forwards accepted beats through a one-entry output register. That register drives the router's `axi_s_*` port directly.

---
 rtl/stream_arbiter_pkg.sv | 16 +
 rtl/stream_arbiter_if.sv | 36 +++
 rtl/stream_arbiter_picker.sv | 33 +++
 rtl/stream_arbiter.sv | 130 +++++++++++++
 tb/tb_stream_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_arbiter_pkg.sv
// Shared types for the stream arbiter slice.
//   arb_state_t : arbiter FSM states (IDLE between grants, BURST while a source owns the output).
//   identity_t  : forwarded routing identity at the default width (identity LSBs plus the
//                 router-select MSB), used by code that works at the default configuration.
package stream_pkg;

    localparam int default_identity_width = 2;

    typedef logic [default_identity_width:0] identity_t;

    typedef enum logic {
        IDLE,
        BURST
    } arb_state_t;

endpackage

// File: rtl/stream_arbiter_if.sv
// Handshake bundle between the upstream sources, the arbiter and the router input.
//   axi_s_* : per-source ready/valid streams (packed arrays indexed by source).
//   axi_m_* : single registered stream into the router's axi_s port.
//   grant   : one-hot owner of the output, all zero between grants.
// Modports:
//   master : the arbiter, which masters the router-facing stream.
//   slave  : the surrounding logic (sources and router).
interface stream_arbiter_if #(
    parameter int identity_width = 2,
    parameter int stream_width   = 32,
    parameter int source_count   = 4
);

    logic [source_count-1:0]                     axi_s_ready;
    logic [source_count-1:0]                     axi_s_valid;
    logic [source_count-1:0][identity_width:0]   axi_s_identity;
    logic [source_count-1:0][stream_width-1:0]   axi_s_stream;

    logic                                        axi_m_ready;
    logic                                        axi_m_valid;
    logic [identity_width:0]                     axi_m_identity;
    logic [stream_width-1:0]                     axi_m_stream;

    logic [source_count-1:0]                     grant;

    modport master (
        input  axi_s_valid, axi_s_identity, axi_s_stream, axi_m_ready,
        output axi_s_ready, axi_m_valid, axi_m_identity, axi_m_stream, grant
    );

    modport slave (
        output axi_s_valid, axi_s_identity, axi_s_stream, axi_m_ready,
        input  axi_s_ready, axi_m_valid, axi_m_identity, axi_m_stream, grant
    );

endinterface

// File: rtl/stream_arbiter_picker.sv
// round_robin_picker: purely combinational round-robin selector.
//   request : one bit per source asking for the output.
//   pointer : index where the search starts; the search wraps modulo source_count.
//   pick    : one-hot first requester at or after pointer (zero when none).
//   found   : high when any request is set.
module round_robin_picker #(
    parameter  int source_count  = 4,
    localparam int pointer_width = $clog2(source_count)
) (
    input  logic [source_count-1:0]  request,
    input  logic [pointer_width-1:0] pointer,
    output logic [source_count-1:0]  pick,
    output logic                     found
);

    logic [pointer_width-1:0] index;

    always_comb begin
        // NOTE: every output gets a default before the loop; a path that skips an
        // assignment would otherwise infer a latch.
        pick  = '0;
        found = 1'b0;
        index = '0;
        for (int offset = 0; offset < source_count; offset++) begin
            index = pointer_width'((int'(pointer) + offset) % source_count);
            if (!found && request[index]) begin
                pick[index] = 1'b1;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arbiter.sv
// stream_arbiter: round-robin arbiter sharing the router input among source_count producers.
// A source is granted for at most burst_limit beats; accepted beats go through a one-entry
// output register that drives the router directly.
//   clock   : single clock.
//   reset_n : asynchronous active-low reset.
//   bus     : stream_arbiter_if master view (per-source axi_s_*, router-facing axi_m_*, grant).
module stream_arbiter
    import stream_pkg::*;
#(
    parameter int identity_width = 2,
    parameter int stream_width   = 32,
    parameter int source_count   = 4,
    parameter int burst_limit    = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    stream_arbiter_if.master bus
);

    localparam int pointer_width = $clog2(source_count);
    localparam int count_width   = $clog2(burst_limit + 1);

    localparam logic [count_width-1:0]   last_beat   = count_width'(burst_limit - 1);
    localparam logic [pointer_width-1:0] last_source = pointer_width'(source_count - 1);

    arb_state_t                 state;
    logic [source_count-1:0]    grant_q;
    logic [pointer_width-1:0]   pointer;
    logic [count_width-1:0]     beat_count;
    logic                       m_valid_q;
    logic [identity_width:0]    m_identity_q;
    logic [stream_width-1:0]    m_stream_q;

    logic [source_count-1:0]    pick;
    logic                       found;
    logic                       out_free;
    logic                       granted_valid;
    logic                       accept;
    logic                       release_burst;
    logic [pointer_width-1:0]   granted_index;
    logic [pointer_width-1:0]   next_pointer;
    logic [identity_width:0]    sel_identity;
    logic [stream_width-1:0]    sel_stream;

    round_robin_picker #(
        .source_count (source_count)
    ) u_picker (
        .request (bus.axi_s_valid),
        .pointer (pointer),
        .pick    (pick),
        .found   (found)
    );

    // Grant is one-hot, so the mux reduces to "take the lane whose grant bit is set".
    always_comb begin
        granted_index = '0;
        sel_identity  = '0;
        sel_stream    = '0;
        for (int i = 0; i < source_count; i++) begin
            if (grant_q[i]) begin
                granted_index = pointer_width'(i);
                sel_identity  = bus.axi_s_identity[i];
                sel_stream    = bus.axi_s_stream[i];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign out_free      = !m_valid_q || bus.axi_m_ready;
    assign granted_valid = |(bus.axi_s_valid & grant_q);
    assign accept        = granted_valid && out_free;

    // Release on the last allowed beat, or when the owner is idle while the output could
    // have taken a beat; backpressure alone never ends a burst.
    assign release_burst = (state == BURST) && out_free
                           && (!granted_valid || beat_count == last_beat);

    assign next_pointer  = (granted_index == last_source) ? '0 : granted_index + 1'b1;

    assign bus.axi_s_ready    = grant_q & {source_count{out_free}};
    assign bus.grant          = grant_q;
    assign bus.axi_m_valid    = m_valid_q;
    assign bus.axi_m_identity = m_identity_q;
    assign bus.axi_m_stream   = m_stream_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            grant_q      <= '0;
            pointer      <= '0;
            beat_count   <= '0;
            m_valid_q    <= 1'b0;
            // NOTE: the payload registers are reset as well so axi_m_* reads zero, not X,
            // straight out of reset.
            m_identity_q <= '0;
            m_stream_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every register here samples
            // the pre-edge values regardless of statement order.
            if (accept) begin
                m_valid_q    <= 1'b1;
                m_identity_q <= sel_identity;
                m_stream_q   <= sel_stream;
            end else if (bus.axi_m_ready) begin
                m_valid_q    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        grant_q    <= pick;
                        beat_count <= '0;
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (accept) begin
                        beat_count <= beat_count + 1'b1;
                    end
                    if (release_burst) begin
                        state   <= IDLE;
                        grant_q <= '0;
                        pointer <= next_pointer;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stream_arbiter.sv
`timescale 1ns/1ps
module tb_stream_arbiter;
    import stream_pkg::*;

    localparam int n_src = 4;
    localparam int id_w  = 2;
    localparam int st_w  = 32;
    localparam int b_lim = 8;

    typedef logic [st_w-1:0] data_t;

    typedef struct {
        identity_t id;
        data_t     data;
    } beat_t;

    typedef struct {
        logic [n_src-1:0] valid;
        logic             m_ready;
        logic [n_src-1:0] exp_grant;
        logic [n_src-1:0] exp_ready;
        logic             exp_mvalid;
        identity_t        exp_id;
        data_t            exp_stream;
    } vector_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    stream_arbiter_if #(.identity_width(id_w), .stream_width(st_w), .source_count(n_src)) bus  ();
    stream_arbiter_if #(.identity_width(id_w), .stream_width(st_w), .source_count(n_src)) bus1 ();

    stream_arbiter #(
        .identity_width (id_w), .stream_width (st_w), .source_count (n_src), .burst_limit (b_lim)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Second instance with the smallest burst, fed the same source stimulus.
    stream_arbiter #(
        .identity_width (id_w), .stream_width (st_w), .source_count (n_src), .burst_limit (1)
    ) dut_single (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus1)
    );

    assign bus1.axi_s_valid    = bus.axi_s_valid;
    assign bus1.axi_s_identity = bus.axi_s_identity;
    assign bus1.axi_s_stream   = bus.axi_s_stream;
    assign bus1.axi_m_ready    = bus.axi_m_ready;

    int               checks = 0;
    int               errors = 0;
    int unsigned      seq  [n_src];
    data_t            base [n_src];
    identity_t        idn  [n_src];
    logic [n_src-1:0] accepted;
    vector_t          vec  [10];

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [n_src-1:0] onehot(input int i);
        logic [n_src-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    task automatic apply_payload();
        for (int i = 0; i < n_src; i++) begin
            bus.axi_s_stream[i]   = base[i] + data_t'(seq[i]);
            bus.axi_s_identity[i] = idn[i];
        end
    endtask

    // Drive this cycle's inputs at the falling edge and let combinational paths settle.
    task automatic set_inputs(input logic [n_src-1:0] v, input logic mr);
        bus.axi_s_valid = v;
        bus.axi_m_ready = mr;
        #1;
    endtask

    // Step through the rising edge; each source moves to its next beat once accepted.
    task automatic advance();
        accepted = bus.axi_s_valid & bus.axi_s_ready;
        @(negedge clock);
        for (int i = 0; i < n_src; i++) begin
            if (accepted[i]) seq[i]++;
        end
        apply_payload();
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        bus.axi_s_valid = '0;
        bus.axi_m_ready = 1'b1;
        accepted        = '0;
        for (int i = 0; i < n_src; i++) begin
            seq[i]  = 0;
            base[i] = 32'hA5A5_0000 + data_t'(i << 12);
            idn[i]  = identity_t'(i);
        end
        apply_payload();
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [n_src-1:0] exp_g;
        logic [n_src-1:0] exp_r;
        logic [n_src-1:0] rv;
        logic             mr;
        int               exp_k;
        int               m_ptr;
        int               m_g;
        int               m_beats;
        bit               free;
        bit               hs;
        bit               got;
        beat_t            q[$];
        beat_t            b;

        // ---------------- table-driven vectors ----------------
        do_reset();
        base[3] = 32'h1234_5678;
        idn[3]  = 3'b101;
        apply_payload();
        //            valid    mr    grant    ready   mv    id      stream
        vec[0] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 32'h0};
        vec[1] = '{4'b1000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 32'h0};
        vec[2] = '{4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b0, 3'b000, 32'h0};
        vec[3] = '{4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 3'b101, 32'h1234_5678};
        vec[4] = '{4'b0000, 1'b0, 4'b1000, 4'b0000, 1'b1, 3'b101, 32'h1234_5678};
        vec[5] = '{4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 3'b101, 32'h1234_5678};
        vec[6] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 32'h0};
        vec[7] = '{4'b1010, 1'b1, 4'b0000, 4'b0000, 1'b0, 3'b000, 32'h0};
        vec[8] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b0, 3'b000, 32'h0};
        vec[9] = '{4'b1010, 1'b1, 4'b0010, 4'b0010, 1'b1, 3'b001, 32'hA5A5_1000};
        for (int r = 0; r < 10; r++) begin
            set_inputs(vec[r].valid, vec[r].m_ready);
            check($sformatf("vec%0d grant", r), bus.grant, vec[r].exp_grant);
            check($sformatf("vec%0d ready", r), bus.axi_s_ready, vec[r].exp_ready);
            check($sformatf("vec%0d m_valid", r), bus.axi_m_valid, vec[r].exp_mvalid);
            if (vec[r].exp_mvalid) begin
                check($sformatf("vec%0d identity", r), bus.axi_m_identity, vec[r].exp_id);
                check($sformatf("vec%0d stream", r), bus.axi_m_stream, vec[r].exp_stream);
            end
            advance();
        end

        // ---------------- reset priority: all sources requesting ----------------
        do_reset();
        for (int c = 0; c < 36; c++) begin
            set_inputs(4'b1111, 1'b1);
            exp_g = (c % 9 == 0) ? '0 : onehot((c / 9) % n_src);
            check($sformatf("prio grant c%0d", c), bus.grant, exp_g);
            check($sformatf("prio ready c%0d", c), bus.axi_s_ready, exp_g);
            exp_g = (c % 2 == 0) ? '0 : onehot((c / 2) % n_src);
            check($sformatf("limit1 grant c%0d", c), bus1.grant, exp_g);
            if (c == 9) check("prio last beat src0", bus.axi_m_stream, 32'hA5A5_0007);
            advance();
        end

        // ---------------- single source: regranted after each bubble ----------------
        do_reset();
        for (int c = 0; c < 27; c++) begin
            set_inputs(4'b0100, 1'b1);
            exp_g = (c % 9 == 0) ? '0 : 4'b0100;
            check($sformatf("single grant c%0d", c), bus.grant, exp_g);
            advance();
        end
        set_inputs(4'b1111, 1'b1);
        check("single idle before regrant", bus.grant, 4'b0000);
        advance();
        set_inputs(4'b1111, 1'b1);
        check("pointer after single-source release", bus.grant, 4'b1000);
        advance();

        // ---------------- backpressure mid-burst ----------------
        do_reset();
        exp_k = 0;
        for (int c = 0; c <= 20; c++) begin
            mr = (c >= 5 && c <= 9) ? 1'b0 : 1'b1;
            set_inputs(4'b0001, mr);
            if (!mr) begin
                check($sformatf("bp hold stream c%0d", c), bus.axi_m_stream, 32'hA5A5_0003);
                check($sformatf("bp hold valid c%0d", c), bus.axi_m_valid, 1'b1);
                check($sformatf("bp ready c%0d", c), bus.axi_s_ready, 4'b0000);
                check($sformatf("bp grant c%0d", c), bus.grant, 4'b0001);
            end
            if (bus.axi_m_valid && bus.axi_m_ready) begin
                check($sformatf("bp order k%0d", exp_k), bus.axi_m_stream, 32'hA5A5_0000 + exp_k);
                exp_k++;
            end
            advance();
        end
        check("bp beat count", exp_k, 13);

        // ---------------- early release, then reset mid-burst ----------------
        do_reset();
        for (int c = 0; c < 4; c++) begin
            set_inputs(4'b0010, 1'b1);
            check($sformatf("early grant c%0d", c), bus.grant, (c == 0) ? 4'b0000 : 4'b0010);
            advance();
        end
        set_inputs(4'b1001, 1'b1);
        check("early drop grant held", bus.grant, 4'b0010);
        advance();
        set_inputs(4'b1001, 1'b1);
        check("early release idle grant", bus.grant, 4'b0000);
        check("early release idle ready", bus.axi_s_ready, 4'b0000);
        advance();
        set_inputs(4'b1001, 1'b1);
        check("early next grant", bus.grant, 4'b1000);
        check("early beats from src1", seq[1], 3);
        advance();
        set_inputs(4'b1111, 1'b1);
        check("pre-reset m_valid", bus.axi_m_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("async reset m_valid", bus.axi_m_valid, 1'b0);
        check("async reset grant", bus.grant, 4'b0000);
        check("async reset ready", bus.axi_s_ready, 4'b0000);
        @(negedge clock);
        reset_n = 1'b1;
        set_inputs(4'b1111, 1'b1);
        check("after reset idle", bus.grant, 4'b0000);
        advance();
        set_inputs(4'b1111, 1'b1);
        check("after reset restart at 0", bus.grant, 4'b0001);
        advance();

        // ---------------- randomized run against a transaction-level model ----------------
        do_reset();
        for (int i = 0; i < n_src; i++) begin
            base[i] = data_t'($urandom);
            idn[i]  = identity_t'($urandom);
        end
        apply_payload();
        rv      = '0;
        m_ptr   = 0;
        m_g     = -1;
        m_beats = 0;
        q.delete();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < n_src; i++) begin
                if (rv[i] && !accepted[i]) rv[i] = ($urandom % 16) != 0;
                else                       rv[i] = ($urandom % 4) != 0;
            end
            mr = ($urandom % 4) != 0;
            set_inputs(rv, mr);

            exp_g = (m_g < 0) ? '0 : onehot(m_g);
            exp_r = (m_g >= 0 && (q.size() == 0 || mr)) ? onehot(m_g) : '0;
            check("rand grant", bus.grant, exp_g);
            check("rand ready", bus.axi_s_ready, exp_r);
            check("rand m_valid", bus.axi_m_valid, q.size() != 0);
            if (q.size() != 0) begin
                check("rand identity", bus.axi_m_identity, q[0].id);
                check("rand stream", bus.axi_m_stream, q[0].data);
            end

            hs = (q.size() != 0) && mr;
            if (hs) void'(q.pop_front());
            if (m_g >= 0) begin
                free = (!hs && q.size() == 0) || hs || mr;
                free = (exp_r != '0);
                if (free && rv[m_g]) begin
                    b.id   = idn[m_g];
                    b.data = base[m_g] + data_t'(seq[m_g]);
                    q.push_back(b);
                    m_beats++;
                end
                if (free && (!rv[m_g] || m_beats == b_lim)) begin
                    m_ptr = (m_g + 1) % n_src;
                    m_g   = -1;
                end
            end else begin
                got = 1'b0;
                for (int k = 0; k < n_src; k++) begin
                    if (!got && rv[(m_ptr + k) % n_src]) begin
                        m_g     = (m_ptr + k) % n_src;
                        m_beats = 0;
                        got     = 1'b1;
                    end
                end
            end
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
